seq_playback_checker: RTL

- Read-side counterpart to the sequence generator. The generator writes random digits into RAM port A; this block reads them back through RAM port B.
- Phase 1 (playback): shows each stored digit on the 7-seg digit bus for one 2-second tick.
- Phase 2 (entry): fetches each digit again and compares it with the player's entered digit. Reports pass/fail and an error count to the game controller.

---
 rtl/orion_pkg.sv | 23 ++
 rtl/seq_rd_port.sv | 44 ++++
 rtl/seq_playback_checker.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/orion_pkg.sv
// Shared definitions for the sequence game datapath.
// Holds the playback/checker state encoding, the default RAM address and digit
// widths, and the display code used for a blank digit.
package orion_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 4;
    localparam logic [3:0]  BLANK_DEF  = 4'hF;

    typedef enum logic [3:0] {
        IDLE,
        S_FETCH,
        S_LOAD,
        SHOW,
        GAP,
        E_FETCH,
        E_LOAD,
        E_WAIT,
        COMPARE,
        DONE
    } seqState_t;

endpackage

// File: rtl/seq_rd_port.sv
// Registered read port for a synchronous RAM with one cycle of read latency.
// A request registers the address; the RAM samples it on the following edge, so
// read data is valid two cycles after the request cycle and dataValid marks it.
// Ports:
//   clk, rst   system clock, asynchronous active-low reset
//   req        issue a read of reqAddr
//   reqAddr    address to read
//   ramAddr    registered address to RAM port B
//   dataValid  high in the cycle the RAM output holds the requested word
module seq_rd_port
    import orion_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] reqAddr,
    output logic [ADDR_W-1:0] ramAddr,
    output logic              dataValid
);

    logic [ADDR_W-1:0] addrQ;
    logic              addrLiveQ;
    logic              dataLiveQ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addrQ     <= '0;
            addrLiveQ <= 1'b0;
            dataLiveQ <= 1'b0;
        end else begin
            addrLiveQ <= req;
            dataLiveQ <= addrLiveQ;
            if (req) begin
                addrQ <= reqAddr;
            end
        end
    end

    assign ramAddr   = addrQ;
    assign dataValid = dataLiveQ;

endmodule

// File: rtl/seq_playback_checker.sv
// Plays back a stored digit sequence from RAM port B, then checks the player's
// entries against it and reports pass/fail plus a mismatch count.
// Build option: SEQ_EARLY_ABORT_EN ends the round at the first mismatch.
// Ports:
//   clk, rst     system clock, asynchronous active-low reset
//   start        begins a round (ignored while busy); seq_len sampled with it
//   tick         two-second pulse, acted on only while showing a digit
//   tick_en      enables the two-second timer while a digit is shown
//   ram_addr     RAM port-B read address; ram_q returns one cycle later
//   disp_digit   digit to the display decoder (BLANK when nothing shown)
//   user_digit   player switch value, committed by user_strobe
//   busy         round in progress
//   entry_rdy    waiting for the player's next digit
//   done         one-cycle end-of-round pulse; pass/err_count held afterwards
module seq_playback_checker
    import orion_pkg::*;
#(
    parameter int unsigned       ADDR_W = ADDR_W_DEF,
    parameter int unsigned       DATA_W = DATA_W_DEF,
    parameter logic [DATA_W-1:0] BLANK  = DATA_W'(BLANK_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   seq_len,
    input  logic              tick,
    output logic              tick_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] disp_digit,
    input  logic [DATA_W-1:0] user_digit,
    input  logic              user_strobe,
    output logic              busy,
    output logic              entry_rdy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count
);

    localparam logic [ADDR_W:0]   MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_LEN = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_IDX = {{(ADDR_W-1){1'b0}}, 1'b1};

    seqState_t         stateQ, stateD;
    logic [ADDR_W:0]   lenQ, lenD;
    logic [ADDR_W-1:0] idxQ, idxD;
    logic [ADDR_W:0]   errQ, errD;
    logic [DATA_W-1:0] dispQ, dispD;
    logic [DATA_W-1:0] expQ, expD;
    logic              busyQ, busyD;
    logic              doneQ, doneD;
    logic              passQ, passD;

    logic              rdReq;
    logic [ADDR_W-1:0] rdAddr;
    logic              rdValid;
    logic              lastIdx;
    logic              finishEntry;

    seq_rd_port #(
        .ADDR_W (ADDR_W)
    ) uRdPort (
        .clk       (clk),
        .rst       (rst),
        .req       (rdReq),
        .reqAddr   (rdAddr),
        .ramAddr   (ram_addr),
        .dataValid (rdValid)
    );

    // lenQ is never zero outside IDLE/DONE, so len-1 cannot underflow here.
    assign lastIdx = ({1'b0, idxQ} == (lenQ - ONE_LEN));

`ifdef SEQ_EARLY_ABORT_EN
    // Any recorded mismatch ends the round; err_count can only be 1 then.
    assign finishEntry = lastIdx || (errQ != '0);
`else
    assign finishEntry = lastIdx;
`endif

    always_comb begin
        stateD = stateQ;
        lenD   = lenQ;
        idxD   = idxQ;
        errD   = errQ;
        dispD  = dispQ;
        expD   = expQ;
        busyD  = busyQ;
        doneD  = 1'b0;
        passD  = passQ;
        rdReq  = 1'b0;
        rdAddr = idxQ;

        unique case (stateQ)
            IDLE: begin
                if (start) begin
                    lenD  = (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
                    idxD  = '0;
                    errD  = '0;
                    passD = 1'b0;
                    busyD = 1'b1;
                    if (seq_len == '0) begin
                        stateD = DONE;
                    end else begin
                        // Address is requested now so it is on the bus in S_FETCH.
                        rdReq  = 1'b1;
                        rdAddr = '0;
                        stateD = S_FETCH;
                    end
                end
            end
            S_FETCH: stateD = S_LOAD;
            S_LOAD: begin
                if (rdValid) begin
                    dispD  = ram_q;
                    stateD = SHOW;
                end
            end
            SHOW: begin
                if (tick) begin
                    if (lastIdx) begin
                        idxD   = '0;
                        stateD = GAP;
                    end else begin
                        idxD   = idxQ + ONE_IDX;
                        rdReq  = 1'b1;
                        rdAddr = idxQ + ONE_IDX;
                        stateD = S_FETCH;
                    end
                end
            end
            GAP: begin
                dispD  = BLANK;
                rdReq  = 1'b1;
                rdAddr = idxQ;
                stateD = E_FETCH;
            end
            E_FETCH: stateD = E_LOAD;
            E_LOAD: begin
                if (rdValid) begin
                    expD   = ram_q;
                    stateD = E_WAIT;
                end
            end
            E_WAIT: begin
                if (user_strobe) begin
                    if ((user_digit != expQ) && (errQ != {(ADDR_W+1){1'b1}})) begin
                        errD = errQ + ONE_LEN;
                    end
                    stateD = COMPARE;
                end
            end
            COMPARE: begin
                if (finishEntry) begin
                    stateD = DONE;
                end else begin
                    idxD   = idxQ + ONE_IDX;
                    rdReq  = 1'b1;
                    rdAddr = idxQ + ONE_IDX;
                    stateD = E_FETCH;
                end
            end
            DONE: begin
                doneD  = 1'b1;
                passD  = (errQ == '0);
                busyD  = 1'b0;
                stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= IDLE;
            lenQ   <= '0;
            idxQ   <= '0;
            errQ   <= '0;
            dispQ  <= BLANK;
            expQ   <= '0;
            busyQ  <= 1'b0;
            doneQ  <= 1'b0;
            passQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            lenQ   <= lenD;
            idxQ   <= idxD;
            errQ   <= errD;
            dispQ  <= dispD;
            expQ   <= expD;
            busyQ  <= busyD;
            doneQ  <= doneD;
            passQ  <= passD;
        end
    end

    assign tick_en    = (stateQ == SHOW);
    assign entry_rdy  = (stateQ == E_WAIT);
    assign disp_digit = dispQ;
    assign busy       = busyQ;
    assign done       = doneQ;
    assign pass       = passQ;
    assign err_count  = errQ;

endmodule
